// File: rtl/i2c_csr_regfile.sv
// i2c_csr_regfile
//   Avalon-MM slave register file sitting between the host bus and the I2C
//   controller core.
//
//   Word map: 0 CTRL (RW), 1 CMD (WO, strobes the core), 2 STATUS (RO mirror),
//             3 IRQ (sticky, write-1-to-clear), 4 PRESCALE (RW), 5 IRQ_MASK (RW),
//             6 and above reserved (read 0, writes ignored).
//
//   Ports
//     clk_i, rst_i                 clock, asynchronous active-high reset
//     amm_address_i                word address
//     amm_read_i / amm_write_i     transfer requests
//     amm_writedata_i              write data
//     amm_byteenable_i             write byte lanes
//     amm_waitrequest_o            stall; only CMD writes while the core is busy
//     amm_readdata_o               read data, held between reads
//     amm_readdatavalid_o          read data qualifier, RD_LAT cycles after accept
//     ctrl_o, prescale_o           register contents to the core
//     cmd_valid_o, cmd_data_o      one-cycle command strobe and its word
//     cmd_ready_i                  core can accept a command
//     status_i                     live core status
//     irq_set_i                    per-bit event pulses
//     irq_o                        level interrupt
module i2c_csr_regfile #(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 5,
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] PRE_RST = 32'h0000_00F9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   amm_address_i,
    input  logic                amm_read_i,
    input  logic                amm_write_i,
    input  logic [DATA_W-1:0]   amm_writedata_i,
    input  logic [DATA_W/8-1:0] amm_byteenable_i,
    output logic                amm_waitrequest_o,
    output logic [DATA_W-1:0]   amm_readdata_o,
    output logic                amm_readdatavalid_o,
    output logic [DATA_W-1:0]   ctrl_o,
    output logic [DATA_W-1:0]   prescale_o,
    output logic                cmd_valid_o,
    output logic [DATA_W-1:0]   cmd_data_o,
    input  logic                cmd_ready_i,
    input  logic [DATA_W-1:0]   status_i,
    input  logic [DATA_W-1:0]   irq_set_i,
    output logic                irq_o
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_IRQ    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_PRE    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(5);

    // Expand byte enables to a per-bit mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = be[i/8];
        end
        return m;
    endfunction

    logic [DATA_W-1:0] ctrl_r, pre_r, mask_r, irq_r;
    logic [DATA_W-1:0] be_mask, wdata_m;
    logic [DATA_W-1:0] irq_clr, irq_next, mask_next;
    logic [DATA_W-1:0] rd_mux;
    logic              wr_acc, rd_acc;

    assign amm_waitrequest_o = amm_write_i & (amm_address_i == A_CMD) & ~cmd_ready_i;
    assign wr_acc  = amm_write_i & ~amm_waitrequest_o;
    // A read issued together with a write is dropped.
    assign rd_acc  = amm_read_i & ~amm_write_i;
    assign be_mask = lane_mask(amm_byteenable_i);
    assign wdata_m = amm_writedata_i & be_mask;

    always_comb begin
        irq_clr   = '0;
        mask_next = mask_r;
        if (wr_acc && amm_address_i == A_IRQ) begin
            irq_clr = wdata_m;
        end
        if (wr_acc && amm_address_i == A_MASK) begin
            mask_next = (mask_r & ~be_mask) | wdata_m;
        end
        // A set pulse wins over a simultaneous clear.
        irq_next = irq_set_i | (irq_r & ~irq_clr);
    end

    // Read data is taken from pre-update register values.
    always_comb begin
        rd_mux = '0;
        case (amm_address_i)
            A_CTRL:   rd_mux = ctrl_r;
            A_STATUS: rd_mux = status_i;
            A_IRQ:    rd_mux = irq_r;
            A_PRE:    rd_mux = pre_r;
            A_MASK:   rd_mux = mask_r;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_r      <= '0;
            pre_r       <= PRE_RST[DATA_W-1:0];
            mask_r      <= '0;
            irq_r       <= '0;
            irq_o       <= 1'b0;
            cmd_valid_o <= 1'b0;
            cmd_data_o  <= '0;
        end else begin
            if (wr_acc && amm_address_i == A_CTRL) begin
                ctrl_r <= (ctrl_r & ~be_mask) | wdata_m;
            end
            if (wr_acc && amm_address_i == A_PRE) begin
                pre_r <= (pre_r & ~be_mask) | wdata_m;
            end
            mask_r      <= mask_next;
            irq_r       <= irq_next;
            irq_o       <= |(irq_next & mask_next);
            cmd_valid_o <= wr_acc && (amm_address_i == A_CMD);
            if (wr_acc && amm_address_i == A_CMD) begin
                cmd_data_o <= wdata_m;
            end
        end
    end

    assign ctrl_o     = ctrl_r;
    assign prescale_o = pre_r;

    // ---- read stage 1: captured at acceptance ----
    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                rdata_p1 <= rd_mux;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            // ---- read stage 2 ----
            logic              vld_p2;
            logic [DATA_W-1:0] rdata_p2;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_p2   <= 1'b0;
                    rdata_p2 <= '0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        rdata_p2 <= rdata_p1;
                    end
                end
            end

            assign amm_readdatavalid_o = vld_p2;
            assign amm_readdata_o      = rdata_p2;
        end else begin : g_lat1
            assign amm_readdatavalid_o = vld_p1;
            assign amm_readdata_o      = rdata_p1;
        end
    endgenerate

endmodule

// File: tb/tb_i2c_csr_regfile.sv
// Testbench for i2c_csr_regfile: two instances (read latency 1 and 2) share
// the same stimulus and are compared against a queue-based reference model.
module tb_i2c_csr_regfile;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  addr;
    logic        rd, wr, ready;
    logic [15:0] wd, status, set;
    logic [1:0]  be;

    logic        wreq1, rdv1, cv1, irq1;
    logic [15:0] rdata1, ctrl1, pre1, cd1;
    logic        wreq2, rdv2, cv2, irq2;
    logic [15:0] rdata2, ctrl2, pre2, cd2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_csr_regfile #(.DATA_W(16), .ADDR_W(5), .RD_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .amm_address_i(addr), .amm_read_i(rd),
        .amm_write_i(wr), .amm_writedata_i(wd), .amm_byteenable_i(be),
        .amm_waitrequest_o(wreq1), .amm_readdata_o(rdata1),
        .amm_readdatavalid_o(rdv1), .ctrl_o(ctrl1), .prescale_o(pre1),
        .cmd_valid_o(cv1), .cmd_data_o(cd1), .cmd_ready_i(ready),
        .status_i(status), .irq_set_i(set), .irq_o(irq1));

    i2c_csr_regfile #(.DATA_W(16), .ADDR_W(5), .RD_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .amm_address_i(addr), .amm_read_i(rd),
        .amm_write_i(wr), .amm_writedata_i(wd), .amm_byteenable_i(be),
        .amm_waitrequest_o(wreq2), .amm_readdata_o(rdata2),
        .amm_readdatavalid_o(rdv2), .ctrl_o(ctrl2), .prescale_o(pre2),
        .cmd_valid_o(cv2), .cmd_data_o(cd2), .cmd_ready_i(ready),
        .status_i(status), .irq_set_i(set), .irq_o(irq2));

    // ---------------- reference model ----------------
    typedef struct { logic v; logic [15:0] d; } rd_t;
    rd_t q1[$];
    rd_t q2[$];
    logic [15:0] m_ctrl, m_pre, m_mask, m_irq, m_cd, m_rd1, m_rd2;
    logic        m_cv, m_irq_o, m_rv1, m_rv2;

    function automatic logic [15:0] bmask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    function automatic logic m_wait();
        return wr && addr == 5'd1 && !ready;
    endfunction

    task automatic model_reset();
        m_ctrl = 16'h0; m_pre = 16'h00F9; m_mask = 16'h0; m_irq = 16'h0;
        m_cd = 16'h0; m_cv = 1'b0; m_irq_o = 1'b0;
        m_rd1 = 16'h0; m_rd2 = 16'h0; m_rv1 = 1'b0; m_rv2 = 1'b0;
        q1.delete(); q2.delete();
        q2.push_back('{v: 1'b0, d: 16'h0});   // latency-2 path holds one entry in flight
    endtask

    task automatic model_step();
        logic [15:0] m, wdm, rv, clr, irq_n, mask_n;
        logic        wacc, racc;
        rd_t         e;
        m    = bmask(be);
        wdm  = wd & m;
        wacc = wr && !m_wait();
        racc = rd && !wr;
        case (addr)
            5'd0:    rv = m_ctrl;
            5'd2:    rv = status;
            5'd3:    rv = m_irq;
            5'd4:    rv = m_pre;
            5'd5:    rv = m_mask;
            default: rv = 16'h0;
        endcase
        clr    = (wacc && addr == 5'd3) ? wdm : 16'h0;
        irq_n  = set | (m_irq & ~clr);
        mask_n = (wacc && addr == 5'd5) ? ((m_mask & ~m) | wdm) : m_mask;
        if (wacc && addr == 5'd0) m_ctrl = (m_ctrl & ~m) | wdm;
        if (wacc && addr == 5'd4) m_pre  = (m_pre & ~m) | wdm;
        m_cv = wacc && addr == 5'd1;
        if (m_cv) m_cd = wdm;
        m_irq   = irq_n;
        m_mask  = mask_n;
        m_irq_o = |(irq_n & mask_n);
        q1.push_back('{v: racc, d: rv});
        q2.push_back('{v: racc, d: rv});
        e = q1.pop_front();
        m_rv1 = e.v; if (e.v) m_rd1 = e.d;
        e = q2.pop_front();
        m_rv2 = e.v; if (e.v) m_rd2 = e.d;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("rdv_l1",   32'(rdv1),   32'(m_rv1));
        chk("rdata_l1", 32'(rdata1), 32'(m_rd1));
        chk("rdv_l2",   32'(rdv2),   32'(m_rv2));
        chk("rdata_l2", 32'(rdata2), 32'(m_rd2));
        chk("ctrl_l1",  32'(ctrl1),  32'(m_ctrl));
        chk("ctrl_l2",  32'(ctrl2),  32'(m_ctrl));
        chk("pre_l1",   32'(pre1),   32'(m_pre));
        chk("pre_l2",   32'(pre2),   32'(m_pre));
        chk("cmdv_l1",  32'(cv1),    32'(m_cv));
        chk("cmdv_l2",  32'(cv2),    32'(m_cv));
        chk("cmdd_l1",  32'(cd1),    32'(m_cd));
        chk("cmdd_l2",  32'(cd2),    32'(m_cd));
        chk("irq_l1",   32'(irq1),   32'(m_irq_o));
        chk("irq_l2",   32'(irq2),   32'(m_irq_o));
    endtask

    // Inputs are driven at the falling edge; this checks the combinational
    // stall, advances the model across the rising edge and checks outputs.
    task automatic cycle();
        #1;
        chk("wreq_l1", 32'(wreq1), 32'(m_wait()));
        chk("wreq_l2", 32'(wreq2), 32'(m_wait()));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0; addr = 5'd0; wd = 16'h0; be = 2'b11; set = 16'h0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_rdv2",  32'(rdv2),   32'h0);
        chk("rst_rd2",   32'(rdata2), 32'h0);
        chk("rst_pre",   32'(pre1),   32'h00F9);
        chk("rst_cmdv",  32'(cv1),    32'h0);
        chk("rst_irq",   32'(irq2),   32'h0);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    typedef struct { logic [4:0] a; logic [15:0] exp; } rvec_t;
    rvec_t rtab[8];
    int    vcnt;

    initial begin
        rst_i = 1'b1; ready = 1'b1; status = 16'h5A3C;
        idle();
        rtab[0] = '{5'd0, 16'h0000};
        rtab[1] = '{5'd1, 16'h0000};
        rtab[2] = '{5'd2, 16'h5A3C};
        rtab[3] = '{5'd3, 16'h0000};
        rtab[4] = '{5'd4, 16'h00F9};
        rtab[5] = '{5'd5, 16'h0000};
        rtab[6] = '{5'd6, 16'h0000};
        rtab[7] = '{5'd7, 16'h0000};

        @(negedge clk);
        do_reset();

        // Reset map readback, both latencies.
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1; addr = rtab[i].a;
            cycle();
            chk($sformatf("map_l1_rdv_%0d", i), 32'(rdv1), 32'h1);
            chk($sformatf("map_l1_%0d", i), 32'(rdata1), 32'(rtab[i].exp));
            chk($sformatf("map_l2_early_%0d", i), 32'(rdv2), 32'h0);
            idle();
            cycle();
            chk($sformatf("map_l2_rdv_%0d", i), 32'(rdv2), 32'h1);
            chk($sformatf("map_l2_%0d", i), 32'(rdata2), 32'(rtab[i].exp));
        end

        // CTRL write with only the low lane enabled.
        wr = 1'b1; addr = 5'd0; wd = 16'hA5C3; be = 2'b01;
        cycle();
        chk("ctrl_be", 32'(ctrl1), 32'h00C3);
        idle(); rd = 1'b1; addr = 5'd0;
        cycle();
        chk("ctrl_rd_l1", 32'(rdata1), 32'h00C3);
        idle();
        cycle();
        chk("ctrl_rd_l2", 32'(rdata2), 32'h00C3);

        // CMD write stalled for three cycles.
        wr = 1'b1; addr = 5'd1; wd = 16'h1234; be = 2'b11; ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("cmd_stall", 32'(wreq1), 32'h1);
            cycle();
            chk("cmd_nostrobe", 32'(cv1), 32'h0);
        end
        ready = 1'b1;
        #1;
        chk("cmd_go", 32'(wreq1), 32'h0);
        cycle();
        chk("cmd_strobe", 32'(cv1), 32'h1);
        chk("cmd_data", 32'(cd1), 32'h1234);
        idle();
        cycle();
        chk("cmd_single", 32'(cv1), 32'h0);
        chk("cmd_hold", 32'(cd1), 32'h1234);

        // Interrupt set, mask, read, clear.
        wr = 1'b1; addr = 5'd5; wd = 16'h0004;
        cycle();
        idle(); set = 16'h0004;
        cycle();
        chk("irq_set", 32'(irq1), 32'h1);
        idle(); rd = 1'b1; addr = 5'd3;
        cycle();
        chk("irq_rd", 32'(rdata1), 32'h0004);
        idle(); wr = 1'b1; addr = 5'd3; wd = 16'h0004;
        cycle();
        chk("irq_w1c", 32'(irq1), 32'h0);

        // Set and clear in the same cycle: set wins.
        idle(); set = 16'h0004;
        cycle();
        idle(); wr = 1'b1; addr = 5'd3; wd = 16'h0004; set = 16'h0004;
        cycle();
        chk("irq_setwins", 32'(irq1), 32'h1);
        idle(); rd = 1'b1; addr = 5'd3;
        cycle();
        chk("irq_setwins_rd", 32'(rdata1), 32'h0004);
        idle(); wr = 1'b1; addr = 5'd3; wd = 16'hFFFF;
        cycle();

        // Eight back-to-back reads.
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            idle();
            if (k < 8) begin rd = 1'b1; addr = 5'(k); end
            cycle();
            chk($sformatf("b2b_l2_%0d", k), 32'(rdv2), 32'((k >= 1 && k <= 8) ? 1 : 0));
            if (rdv2) vcnt++;
        end
        chk("b2b_count", 32'(vcnt), 32'd8);

        // Reset with a read in flight.
        idle(); rd = 1'b1; addr = 5'd4;
        cycle();
        idle();
        do_reset();
        cycle();
        chk("rst_inflight_l2", 32'(rdv2), 32'h0);
        chk("rst_inflight_rd", 32'(rdata2), 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rd     = ($urandom_range(0, 2) == 0);
            wr     = ($urandom_range(0, 2) == 0);
            addr   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd     = 16'($urandom);
            be     = 2'($urandom);
            ready  = ($urandom_range(0, 3) != 0);
            status = 16'($urandom);
            set    = ($urandom_range(0, 5) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
